// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the shared ALU/memory datapath.
// Optional perf counters (instret, cycles) enabled by MCFSM_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        illegal,
  output logic        error,
`ifdef MCFSM_PERF_CNT_EN
  output logic [31:0] instret,
  output logic [31:0] cycles,
`endif
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [6:0]        opcode_q;
  logic [WAIT_W-1:0] wait_q;
  logic              bad_op;
  logic              wait_hit;

  // Branch outcome is applied by the datapath via PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_hit = (wait_q == WAIT_LAST);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)     state_d = S_DECODE;
        else if (wait_hit) state_d = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R, OP_I:   state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode_q == OP_LW) state_d = S_MEMRD;
        else                   state_d = S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready)     state_d = S_MEMWB;
        else if (wait_hit) state_d = S_ERROR;
      end
      S_MEMWR: begin
        if (mem_ready)     state_d = S_FETCH;
        else if (wait_hit) state_d = S_ERROR;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR load and PC+4 only on the completing cycle.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b10;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        ALUSrcB = (opcode_q == OP_I) ? 2'b10 : 2'b00;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      wait_q   <= '0;
      illegal  <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (state_d != state_q || mem_ready || !mem_req)
        wait_q <= '0;
      else
        wait_q <= wait_q + 1'b1;
      if (bad_op)              illegal <= 1'b1;
      if (state_d == S_ERROR)  error   <= 1'b1;
    end
  end

`ifdef MCFSM_PERF_CNT_EN
  logic retire;
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      if (state_q != S_ERROR) cycles  <= cycles + 32'd1;
      if (retire)             instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm.
// Expected state sequences are hand-derived per instruction class.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        PCSource;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        MemtoReg;
  logic        RegWrite;
  logic        illegal;
  logic        error;
  logic [3:0]  state;
`ifdef MCFSM_PERF_CNT_EN
  logic [31:0] instret;
  logic [31:0] cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT(15),
    .WAIT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .zero(zero),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .IorD(IorD),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .IRWrite(IRWrite),
    .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond),
    .PCSource(PCSource),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp),
    .MemtoReg(MemtoReg),
    .RegWrite(RegWrite),
    .illegal(illegal),
    .error(error),
`ifdef MCFSM_PERF_CNT_EN
    .instret(instret),
    .cycles(cycles),
`endif
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #12;
    check("rst_state", 32'(state), 0);
    check("rst_error", 32'(error), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_memreq", 32'(mem_req), 1);
    check("rst_memrd", 32'(MemRead), 1);
    check("rst_srcb", 32'(ALUSrcB), 1);
    check("rst_irw", 32'(IRWrite), 0);

    // R-type, zero-wait memory: 0,1,6,7,0
    @(negedge clk);
    reset = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;
    #1;
    check("r_irw", 32'(IRWrite), 1);
    check("r_pcw", 32'(PCWrite), 1);
    tick();
    check("r_s1", 32'(state), 1);
    check("r_dec_srcb", 32'(ALUSrcB), 2);
    check("r_dec_rw", 32'(RegWrite), 0);
    tick();
    check("r_s6", 32'(state), 6);
    check("r_ex_srcb", 32'(ALUSrcB), 0);
    check("r_ex_op", 32'(ALUOp), 2);
    check("r_ex_srca", 32'(ALUSrcA), 1);
    check("r_ex_rw", 32'(RegWrite), 0);
    tick();
    check("r_s7", 32'(state), 7);
    check("r_wb_rw", 32'(RegWrite), 1);
    check("r_wb_m2r", 32'(MemtoReg), 0);
    tick();
    check("r_s0", 32'(state), 0);

    // lw with 3 wait cycles in MEMRD
    opcode = OP_LW;
    tick();
    check("lw_s1", 32'(state), 1);
    tick();
    check("lw_s2", 32'(state), 2);
    check("lw_adr_srca", 32'(ALUSrcA), 1);
    check("lw_adr_srcb", 32'(ALUSrcB), 2);
    tick();
    mem_ready = 1'b0;
    check("lw_s3", 32'(state), 3);
    check("lw_req", 32'(mem_req), 1);
    check("lw_iord", 32'(IorD), 1);
    check("lw_rd", 32'(MemRead), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_wait_s", 32'(state), 3);
      check("lw_wait_req", 32'(mem_req), 1);
    end
    mem_ready = 1'b1;
    tick();
    check("lw_s4", 32'(state), 4);
    check("lw_wb_rw", 32'(RegWrite), 1);
    check("lw_wb_m2r", 32'(MemtoReg), 1);
    check("lw_wb_req", 32'(mem_req), 0);
    tick();
    check("lw_s0", 32'(state), 0);

    // beq taken: 0,1,8,0
    opcode = OP_BEQ;
    zero = 1'b1;
    tick();
    check("beq_s1", 32'(state), 1);
    tick();
    check("beq_s8", 32'(state), 8);
    check("beq_pwc", 32'(PCWriteCond), 1);
    check("beq_op", 32'(ALUOp), 1);
    check("beq_psrc", 32'(PCSource), 1);
    check("beq_srcb", 32'(ALUSrcB), 0);
    tick();
    check("beq_s0", 32'(state), 0);

    // sw: 0,1,2,5,0
    opcode = OP_SW;
    tick();
    tick();
    check("sw_s2", 32'(state), 2);
    tick();
    check("sw_s5", 32'(state), 5);
    check("sw_mw", 32'(MemWrite), 1);
    check("sw_iord", 32'(IorD), 1);
    check("sw_mr", 32'(MemRead), 0);
    tick();
    check("sw_s0", 32'(state), 0);

    // illegal opcode acts as NOP and sets sticky flag
    opcode = OP_BAD;
    tick();
    check("ill_s1", 32'(state), 1);
    check("ill_pre", 32'(illegal), 0);
    check("ill_rw1", 32'(RegWrite), 0);
    tick();
    check("ill_s0", 32'(state), 0);
    check("ill_set", 32'(illegal), 1);
    check("ill_mw", 32'(MemWrite), 0);
    opcode = OP_R;
    repeat (4) tick();
    check("ill_r_s0", 32'(state), 0);
    check("ill_sticky", 32'(illegal), 1);

    // ready on the 15th FETCH cycle still completes
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("to_hold_s", 32'(state), 0);
    check("to_hold_err", 32'(error), 0);
    mem_ready = 1'b1;
    #1;
    check("to_irw", 32'(IRWrite), 1);
    tick();
    check("to_dec", 32'(state), 1);
    check("to_noerr", 32'(error), 0);
    repeat (3) tick();
    check("to_back_s0", 32'(state), 0);

    // 15 wait cycles with no ready -> ERROR
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("to_14_s", 32'(state), 0);
    tick();
    check("to_err_s", 32'(state), 9);
    check("to_err", 32'(error), 1);
    check("to_err_req", 32'(mem_req), 0);
    check("to_err_rd", 32'(MemRead), 0);
    mem_ready = 1'b1;
    #1;
    check("to_err_irw", 32'(IRWrite), 0);
    tick();
    check("to_err_stay", 32'(state), 9);

    // async reset during MEMWR wait
    reset = 1'b1;
    #1;
    check("rs_state", 32'(state), 0);
    check("rs_error", 32'(error), 0);
    check("rs_illegal", 32'(illegal), 0);
    @(negedge clk);
    reset = 1'b0;
    opcode = OP_SW;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("rs_s5", 32'(state), 5);
    check("rs_mw_pre", 32'(MemWrite), 1);
    tick();
    check("rs_s5_wait", 32'(state), 5);
    #2;
    reset = 1'b1;
    #1;
    check("rs_async_s", 32'(state), 0);
    check("rs_async_mw", 32'(MemWrite), 0);
`ifdef MCFSM_PERF_CNT_EN
    check("rs_instret", instret, 0);
    check("rs_cycles", cycles, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;
    repeat (4) tick();
    check("post_rs_s0", 32'(state), 0);
`ifdef MCFSM_PERF_CNT_EN
    check("pc_instret", instret, 1);
    check("pc_cycles", cycles, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RISC-V core. Replaces per-opcode single-cycle decode with a state machine that drives a shared ALU/memory datapath over several cycles per instruction.
- Supports R-type (0110011), I-type ALU (0010011), lw (0000011), sw (0100011) and beq (1100011).
- Stalls on a ready handshake with unified instruction/data memory.
- Times out on a hung memory access.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive wait cycles on one memory request before entering ERROR. Range 1..255.
- WAIT_W, 8: width of the wait counter. Must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- opcode  in  7  instruction[6:0] from the instruction register
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory completed current request this cycle
- mem_req  out  1  memory request valid; held until mem_ready
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  read request
- MemWrite  out  1  write request
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC update
- PCWriteCond  out  1  PC update gated by zero (branch)
- PCSource  out  1  0 = ALU result, 1 = ALUOut (branch target)
- ALUSrcA  out  1  0 = PC, 1 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = const 4, 10 = imm
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- MemtoReg  out  1  1 = MDR to register file
- RegWrite  out  1  register file write enable
- illegal  out  1  sticky: unsupported opcode decoded
- error  out  1  sticky: memory timeout
- state  out  4  current state code, for debug

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ERROR=9.
- All outputs are Moore, decoded from state only. Every output not listed for a state is 0.
- Reset (async): state=FETCH, wait counter=0, illegal=0, error=0. Outputs immediately take FETCH values.
- FETCH
  - Outputs: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite=1 and PCWrite=1 are qualified by mem_ready; they are the only Mealy terms. PC+4 is written on the cycle mem_ready=1.
  - mem_ready -> DECODE; otherwise stay.
- DECODE
  - Outputs: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute).
  - lw/sw -> MEMADR; R-type/I-type -> EXEC; beq -> BRANCH.
  - Any other opcode: illegal<=1, next FETCH (instruction treated as NOP).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_req=1, MemRead=1, IorD=1. mem_ready -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1. Next FETCH.
- MEMWR: mem_req=1, MemWrite=1, IorD=1. mem_ready -> FETCH.
- EXEC
  - Outputs: ALUSrcA=1, ALUOp=10. ALUSrcB=00 for R-type, 10 for I-type. The opcode is latched in DECODE so it stays stable.
  - Next ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Next FETCH.
- ERROR: all control outputs 0, error=1. Left only by reset.
- Instruction latency: lw 5 cycles, sw 4, R/I 4, beq 3, each with zero-wait memory. Every wait cycle adds 1.
- Wait counter (WAIT_W bits)
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever mem_ready=1.
  - Increments each cycle mem_req=1 && !mem_ready.
  - Reaching MEM_TIMEOUT with mem_ready still 0 -> ERROR next cycle, error<=1.
  - mem_ready arriving on the timeout cycle wins: normal transition, no error.
- mem_ready outside mem_req states is ignored.
- mem_req is never deasserted mid-request except by reset.
- Reset asserted mid-instruction aborts it. No partial writes are issued after reset is asserted.
- illegal and error are sticky until reset.

Optional Feature:
- Macro: MCFSM_PERF_CNT_EN.
- Defined: adds ports instret (out, 32) and cycles (out, 32), both reset to 0.
  - cycles increments every clock outside ERROR.
  - instret increments on each transition into FETCH from MEMWB, MEMWR(ready), ALUWB or BRANCH.
  - Illegal-opcode returns do not count toward instret.
  - Both wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then R-type (opcode 0110011), mem_ready tied 1 -> states 0,1,6,7,0. RegWrite=1 only in state 7. ALUSrcB=00 in EXEC.
- lw (0000011) with mem_ready delayed 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0. mem_req held 4 cycles. RegWrite & MemtoReg high in MEMWB.
- beq (1100011), zero=1 -> 0,1,8,0. PCWriteCond=1 and ALUOp=01 in BRANCH. sw -> 0,1,2,5,0 with MemWrite=1, IorD=1 in MEMWR.
- opcode 1111111 -> illegal=1 after DECODE, back to FETCH, no RegWrite/MemWrite pulses. illegal stays 1 until reset.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> ERROR (state=9, error=1) after 15 wait cycles. mem_ready at exactly the 15th cycle -> DECODE, error=0.
- Assert reset during MEMWR wait -> state=0 asynchronously, MemWrite=0 the same cycle. With MCFSM_PERF_CNT_EN, instret=0 and cycles=0.
